// File: rtl/key_event_decoder.sv
// Classifies debounced key events into short press, double click, long press and auto-repeat.
// Every classified event is emitted as a registered single-cycle pulse.
module key_event_decoder #(
   parameter int LONG_CYC   = 50_000_000,
   parameter int DCLICK_CYC = 15_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int CNT_W      = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_flag,
   input  logic i_key_state,
   output logic o_short_press,
   output logic o_double_click,
   output logic o_long_press,
   output logic o_repeat,
   output logic o_busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HOLD = 3'd2,
      WAIT2     = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             press, release_ev;
   logic             short_next, double_next, long_next, repeat_next;

   assign press      = i_key_flag & ~i_key_state;
   assign release_ev = i_key_flag &  i_key_state;

   // Key events are tested before timer terminals so an event landing on
   // the terminal cycle always wins.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      next_state  = state;
      cnt_next    = cnt + CNT_W'(1);
      short_next  = 1'b0;
      double_next = 1'b0;
      long_next   = 1'b0;
      repeat_next = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (press) next_state = PRESS1;
         end
         PRESS1: begin
            if (release_ev) begin
               next_state = WAIT2;
            end else if (cnt == LONG_LAST) begin
               long_next  = 1'b1;
               next_state = LONG_HOLD;
            end
         end
         LONG_HOLD: begin
            if (release_ev) begin
               next_state = IDLE;
            end else if (cnt == REPEAT_LAST) begin
               repeat_next = 1'b1;
               cnt_next    = '0;
            end
         end
         WAIT2: begin
            if (press) begin
               next_state = PRESS2;
            end else if (cnt == DCLICK_LAST) begin
               short_next = 1'b1;
               next_state = IDLE;
            end
         end
         PRESS2: begin
            cnt_next = '0;
            if (release_ev) begin
               double_next = 1'b1;
               next_state  = IDLE;
            end
         end
         default: begin
            cnt_next   = '0;
            next_state = IDLE;
         end
      endcase
      if (next_state != state) cnt_next = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         o_short_press  <= 1'b0;
         o_double_click <= 1'b0;
         o_long_press   <= 1'b0;
         o_repeat       <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         state          <= next_state;
         cnt            <= cnt_next;
         o_short_press  <= short_next;
         o_double_click <= double_next;
         o_long_press   <= long_next;
         o_repeat       <= repeat_next;
         o_busy         <= (next_state != IDLE);
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: directed gestures push expected pulses,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_key_event_decoder;

   localparam int LONG_CYC   = 100;
   localparam int DCLICK_CYC = 40;
   localparam int REPEAT_CYC = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_flag = 1'b0;
   logic key_state = 1'b1;
   logic short_press, double_click, long_press, repeat_pulse, busy;

   key_event_decoder #(
      .LONG_CYC  (LONG_CYC),
      .DCLICK_CYC(DCLICK_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .CNT_W     (26)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_key_flag    (key_flag),
      .i_key_state   (key_state),
      .o_short_press (short_press),
      .o_double_click(double_click),
      .o_long_press  (long_press),
      .o_repeat      (repeat_pulse),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   // cyc == n during the cycle that starts at the n-th rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_SHORT = 0, EV_DOUBLE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_t;
   typedef struct {
      ev_t kind;
      int  at;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   base = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every emitted pulse must match the head of the scoreboard.
   int   mon_n;
   ev_t  mon_k;
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         mon_n = int'(short_press) + int'(double_click) + int'(long_press) + int'(repeat_pulse);
         if (mon_n > 1) check("one_pulse_per_cycle", mon_n, 1);
         if (mon_n >= 1) begin
            mon_k = short_press ? EV_SHORT : double_click ? EV_DOUBLE :
                    long_press ? EV_LONG : EV_REPEAT;
            if (sb.size() == 0) begin
               check("unexpected_pulse", int'(mon_k), -1);
            end else begin
               mon_e = sb.pop_front();
               check("pulse_kind", int'(mon_k), int'(mon_e.kind));
               check("pulse_cycle", cyc, mon_e.at);
            end
         end
      end
   end

   task automatic expect_ev(input ev_t kind, input int t);
      sb.push_back('{kind, base + t});
   endtask

   task automatic wait_to(input int t);
      int guard = 0;
      while (cyc < base + t && guard < 10000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != base + t) check("schedule_cycle", cyc, base + t);
   endtask

   // Drive one key event so it is sampled as occurring in relative cycle t.
   task automatic key_at(input int t, input logic st);
      wait_to(t);
      key_flag  = 1'b1;
      key_state = st;
      @(negedge clk);
      key_flag  = 1'b0;
      key_state = 1'b1;
   endtask

   task automatic start_test();
      @(negedge clk);
      base = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_pulses", int'({short_press, double_click, long_press, repeat_pulse}), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single press with a redundant release during WAIT2: short pulse at 71.
      start_test();
      expect_ev(EV_SHORT, 71);
      key_at(0, 1'b0);
      wait_to(10);
      check("busy_in_press1", busy, 1);
      key_at(30, 1'b1);
      key_at(35, 1'b1);
      wait_to(70);
      check("busy_before_short", busy, 1);
      wait_to(71);
      check("busy_after_short", busy, 0);
      wait_to(80);
      check("sb_empty_short", sb.size(), 0);

      // Double click: pulse on second release, no short pulse afterwards.
      start_test();
      expect_ev(EV_DOUBLE, 61);
      key_at(0, 1'b0);
      key_at(30, 1'b1);
      key_at(50, 1'b0);
      key_at(60, 1'b1);
      wait_to(61);
      check("busy_after_double", busy, 0);
      wait_to(120);
      check("sb_empty_double", sb.size(), 0);

      // Long press with a redundant press that must not restart the count.
      start_test();
      expect_ev(EV_LONG, 101);
      expect_ev(EV_REPEAT, 121);
      expect_ev(EV_REPEAT, 141);
      expect_ev(EV_REPEAT, 161);
      key_at(0, 1'b0);
      key_at(10, 1'b0);
      wait_to(100);
      check("busy_holding", busy, 1);
      key_at(170, 1'b1);
      wait_to(171);
      check("busy_after_long_release", busy, 0);
      wait_to(200);
      check("sb_empty_long", sb.size(), 0);

      // Release on the PRESS1 terminal cycle: no long pulse, short follows.
      start_test();
      expect_ev(EV_SHORT, 141);
      key_at(0, 1'b0);
      key_at(100, 1'b1);
      wait_to(160);
      check("sb_empty_press1_terminal", sb.size(), 0);

      // Second press on the WAIT2 terminal cycle: no short, double click at 81.
      start_test();
      expect_ev(EV_DOUBLE, 81);
      key_at(0, 1'b0);
      key_at(30, 1'b1);
      key_at(70, 1'b0);
      key_at(80, 1'b1);
      wait_to(130);
      check("sb_empty_wait2_terminal", sb.size(), 0);

      // Release on the LONG_HOLD repeat terminal: no repeat pulse.
      start_test();
      expect_ev(EV_LONG, 101);
      key_at(0, 1'b0);
      key_at(120, 1'b1);
      wait_to(121);
      check("busy_after_hold_terminal", busy, 0);
      wait_to(160);
      check("sb_empty_hold_terminal", sb.size(), 0);

      // Reset in the middle of PRESS1 abandons the gesture entirely.
      start_test();
      key_at(0, 1'b0);
      wait_to(50);
      rst_n = 1'b0;
      #1;
      check("busy_during_reset", busy, 0);
      wait_to(55);
      rst_n = 1'b1;
      key_at(60, 1'b1);
      wait_to(70);
      check("busy_after_reset", busy, 0);
      wait_to(200);
      check("busy_idle_after_reset", busy, 0);
      check("sb_empty_reset", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
